// File: rtl/quant_pkg.sv
// Shared widths, the per-channel parameter record and rounding constants for the
// requantizer pipeline.
package quant_pkg;

   localparam int ACC_W = 32;
   localparam int SH_W  = 5;
   localparam int OUT_W = 8;
   localparam int NCH   = 64;
   localparam int CH_W  = $clog2(NCH);

   // Half of the 2^(ACC_W-1) divisor, added before the high-half extraction.
   localparam logic signed [2*ACC_W-1:0] Q_NUDGE =
      {{(ACC_W+1){1'b0}}, 1'b1, {(ACC_W-2){1'b0}}};

   typedef struct packed {
      logic signed [ACC_W-1:0] qmul;
      logic [SH_W-1:0]         shift;
      logic signed [ACC_W-1:0] offset;
   } qparam_t;

endpackage

// File: rtl/quant_round.sv
// Rounding right shift by a power of two, zero-point offset and activation clamp.
// Purely combinational; also flags beats that the clamp had to touch.
module quant_round
   import quant_pkg::*;
(
   input  logic signed [ACC_W-1:0] hi,
   input  logic [SH_W-1:0]         shift,
   input  logic signed [ACC_W-1:0] offset,
   input  logic signed [OUT_W-1:0] act_min,
   input  logic signed [OUT_W-1:0] act_max,
   output logic signed [OUT_W-1:0] q,
   output logic                    sat
);

   logic [ACC_W-1:0]        mask;
   logic [ACC_W-1:0]        rem;
   logic [ACC_W-1:0]        thr;
   logic signed [ACC_W-1:0] asr;
   logic signed [ACC_W-1:0] shifted;
   logic signed [ACC_W:0]   r2;
   logic signed [ACC_W:0]   lo_ext;
   logic signed [ACC_W:0]   hi_ext;

   // Round half away from zero, then offset in one extra bit so the sum cannot wrap.
   // The clamp applies max(act_min) first, so an inverted window always yields act_max.
   always_comb begin
      mask    = (ACC_W'(1) << shift) - ACC_W'(1);
      rem     = hi & mask;
      thr     = (mask >> 1) + ACC_W'(hi[ACC_W-1]);
      asr     = hi >>> shift;
      shifted = asr + {{(ACC_W-1){1'b0}}, (rem > thr)};
      r2      = {shifted[ACC_W-1], shifted} + {offset[ACC_W-1], offset};
      lo_ext  = {{(ACC_W+1-OUT_W){act_min[OUT_W-1]}}, act_min};
      hi_ext  = {{(ACC_W+1-OUT_W){act_max[OUT_W-1]}}, act_max};
      sat     = (r2 < lo_ext) || (r2 > hi_ext);
      if ((lo_ext > hi_ext) || (r2 > hi_ext)) begin
         q = act_max;
      end else if (r2 < lo_ext) begin
         q = act_min;
      end else begin
         q = r2[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/quant_pipe.sv
// Four-stage per-channel requantizer: table read, multiply, rounded high half,
// shift/offset/clamp. The whole pipe advances together under output backpressure.
module quant_pipe
   import quant_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cfg_we,
   input  logic [CH_W-1:0]         cfg_addr,
   input  logic signed [ACC_W-1:0] cfg_qmul,
   input  logic [SH_W-1:0]         cfg_shift,
   input  logic signed [ACC_W-1:0] cfg_offset,
   input  logic signed [OUT_W-1:0] act_min,
   input  logic signed [OUT_W-1:0] act_max,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [ACC_W-1:0] in_acc,
   input  logic [CH_W-1:0]         in_ch,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] out_data,
   output logic                    out_last,
   output logic [15:0]             sat_cnt,
   input  logic                    sat_clr
);

   localparam logic signed [ACC_W-1:0]   INT_MIN   = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic signed [ACC_W-1:0]   INT_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [2*ACC_W-1:0] NEG_NUDGE = (2*ACC_W)'(1) - Q_NUDGE;

   qparam_t mem [NCH];
   qparam_t s0_p;

   logic                      adv;
   logic                      s0_v, s0_last;
   logic signed [ACC_W-1:0]   s0_acc;
   logic                      s1_v, s1_last, s1_special;
   logic signed [2*ACC_W-1:0] s1_prod;
   logic [SH_W-1:0]           s1_shift;
   logic signed [ACC_W-1:0]   s1_offset;
   logic                      s2_v, s2_last;
   logic signed [ACC_W-1:0]   s2_hi, s2_offset;
   logic [SH_W-1:0]           s2_shift;
   logic                      out_sat;

   logic signed [2*ACC_W-1:0] prod, biased;
   logic signed [ACC_W-1:0]   hi;
   logic                      special;
   logic signed [OUT_W-1:0]   q;
   logic                      q_sat;

   assign adv      = ~out_valid | out_ready;
   assign in_ready = adv;

   // Parameter table: the registered read sees the old entry on a same-address write.
   always_ff @(posedge clk) begin
      if (cfg_we) begin
         mem[cfg_addr] <= '{qmul: cfg_qmul, shift: cfg_shift, offset: cfg_offset};
      end
   end

   always_ff @(posedge clk) begin
      if (adv) begin
         s0_p <= mem[in_ch];
      end
   end

   always_comb begin
      prod    = (2*ACC_W)'(s0_acc) * (2*ACC_W)'($signed(s0_p.qmul));
      special = (s0_acc == INT_MIN) && (s0_p.qmul == INT_MIN);
   end

   // Divide by 2^(ACC_W-1) toward zero: floor via the slice, +1 for inexact negatives.
   always_comb begin
      biased = s1_prod + (s1_prod[2*ACC_W-1] ? NEG_NUDGE : Q_NUDGE);
      hi     = biased[2*ACC_W-2:ACC_W-1]
             + ACC_W'(biased[2*ACC_W-1] && (biased[ACC_W-2:0] != '0));
      if (s1_special) begin
         hi = INT_MAX;
      end
   end

   quant_round u_round (
      .hi      (s2_hi),
      .shift   (s2_shift),
      .offset  (s2_offset),
      .act_min (act_min),
      .act_max (act_max),
      .q       (q),
      .sat     (q_sat)
   );

   // Every stage moves on adv only, so bubbles stay where they are and order holds.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s0_v       <= 1'b0;
         s0_last    <= 1'b0;
         s0_acc     <= '0;
         s1_v       <= 1'b0;
         s1_last    <= 1'b0;
         s1_special <= 1'b0;
         s1_prod    <= '0;
         s1_shift   <= '0;
         s1_offset  <= '0;
         s2_v       <= 1'b0;
         s2_last    <= 1'b0;
         s2_hi      <= '0;
         s2_shift   <= '0;
         s2_offset  <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_last   <= 1'b0;
         out_sat    <= 1'b0;
      end else if (adv) begin
         s0_v       <= in_valid;
         s0_last    <= in_last;
         s0_acc     <= in_acc;
         s1_v       <= s0_v;
         s1_last    <= s0_last;
         s1_special <= special;
         s1_prod    <= prod;
         s1_shift   <= s0_p.shift;
         s1_offset  <= s0_p.offset;
         s2_v       <= s1_v;
         s2_last    <= s1_last;
         s2_hi      <= hi;
         s2_shift   <= s1_shift;
         s2_offset  <= s1_offset;
         out_valid  <= s2_v;
         out_data   <= q;
         out_last   <= s2_last;
         out_sat    <= q_sat;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_cnt <= '0;
      end else if (sat_clr) begin
         sat_cnt <= '0;
      end else if (out_valid && out_ready && out_sat && (sat_cnt != 16'hFFFF)) begin
         sat_cnt <= sat_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_quant_pipe.sv
// Directed bench for quant_pipe: expected beats are queued at acceptance from a
// reference model of the requantizer math and popped as outputs leave the pipe.
module tb_quant_pipe;
   import quant_pkg::*;

   typedef struct {
      logic signed [7:0] data;
      logic              last;
      bit                sat;
   } exp_t;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    cfg_we;
   logic [CH_W-1:0]         cfg_addr;
   logic signed [ACC_W-1:0] cfg_qmul;
   logic [SH_W-1:0]         cfg_shift;
   logic signed [ACC_W-1:0] cfg_offset;
   logic signed [OUT_W-1:0] act_min;
   logic signed [OUT_W-1:0] act_max;
   logic                    in_valid;
   logic                    in_ready;
   logic signed [ACC_W-1:0] in_acc;
   logic [CH_W-1:0]         in_ch;
   logic                    in_last;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [OUT_W-1:0] out_data;
   logic                    out_last;
   logic [15:0]             sat_cnt;
   logic                    sat_clr;

   int   nAsserts = 0;
   int   nFail    = 0;
   int   expSat   = 0;
   exp_t scb[$];
   logic signed [31:0] shQ[64];
   logic signed [31:0] shO[64];
   int                 shS[64];

   quant_pipe dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_qmul   (cfg_qmul),
      .cfg_shift  (cfg_shift),
      .cfg_offset (cfg_offset),
      .act_min    (act_min),
      .act_max    (act_max),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_acc     (in_acc),
      .in_ch      (in_ch),
      .in_last    (in_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .sat_cnt    (sat_cnt),
      .sat_clr    (sat_clr)
   );

   always #5 clk = ~clk;

   // Reference requantizer written straight from the arithmetic definition.
   function automatic exp_t model(logic signed [31:0] acc, int ch, logic last);
      exp_t   m;
      longint prod, nudge, hi, mask, rem, thr, r2, v, mn, mx;
      int     sh;
      sh   = shS[ch];
      prod = longint'(acc) * longint'(shQ[ch]);
      if (acc == 32'h8000_0000 && shQ[ch] == 32'h8000_0000) begin
         hi = (longint'(1) << 31) - 1;
      end else begin
         nudge = (prod >= 0) ? (longint'(1) << 30) : (1 - (longint'(1) << 30));
         hi    = (prod + nudge) / (longint'(1) << 31);
      end
      mask = (longint'(1) << sh) - 1;
      rem  = hi & mask;
      thr  = (mask >> 1) + ((hi < 0) ? 1 : 0);
      r2   = (hi >>> sh) + ((rem > thr) ? 1 : 0) + longint'(shO[ch]);
      mn   = longint'(act_min);
      mx   = longint'(act_max);
      v    = r2;
      if (v < mn) v = mn;
      if (v > mx) v = mx;
      m.data = v[7:0];
      m.last = last;
      m.sat  = (r2 < mn) || (r2 > mx);
      return m;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(string tag, logic signed [63:0] obs, logic signed [63:0] expv);
      nAsserts++;
      assert (obs === expv)
      else begin
         nFail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // One cycle of stimulus: optional beat (held until accepted) and optional table write.
   task automatic applyStimulus(bit doBeat, logic signed [31:0] acc, int ch, logic last,
                                bit doCfg, int addr, logic signed [31:0] qm, int sh,
                                logic signed [31:0] off);
      exp_t e;
      int   n = 0;
      in_valid   = doBeat;
      in_acc     = acc;
      in_ch      = CH_W'(ch);
      in_last    = last;
      cfg_we     = doCfg;
      cfg_addr   = CH_W'(addr);
      cfg_qmul   = qm;
      cfg_shift  = SH_W'(sh);
      cfg_offset = off;
      if (doBeat) begin
         while (n < 200) begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            n++;
         end
         checkOutput("accept_timeout", n < 200, 1);
      end
      tick;
      if (doBeat) begin
         e = model(acc, ch, last);
         scb.push_back(e);
         if (e.sat) expSat++;
      end
      if (doCfg) begin
         shQ[addr] = qm;
         shS[addr] = sh;
         shO[addr] = off;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      cfg_we   = 1'b0;
   endtask

   task automatic sendBeat(logic signed [31:0] acc, int ch, logic last);
      applyStimulus(1'b1, acc, ch, last, 1'b0, 0, 0, 0, 0);
   endtask

   task automatic writeCfg(int addr, logic signed [31:0] qm, int sh, logic signed [31:0] off);
      applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, addr, qm, sh, off);
   endtask

   // Called just after the accepting edge, which counts as edge 1.
   task automatic checkLatency(string tag);
      int n = 1;
      while (out_valid !== 1'b1 && n < 12) begin
         tick;
         n++;
      end
      checkOutput(tag, n, 4);
   endtask

   task automatic drain;
      int n = 0;
      while (scb.size() != 0 && n < 100) begin
         tick;
         n++;
      end
      checkOutput("drain", scb.size(), 0);
   endtask

   // Scoreboard pop: a beat transfers on the next rising edge when valid and ready.
   always @(negedge clk) begin
      exp_t e;
      if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
         checkOutput("beat_expected", scb.size() > 0, 1);
         if (scb.size() > 0) begin
            e = scb.pop_front();
            checkOutput("out_data", out_data, e.data);
            checkOutput("out_last", out_last, e.last);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_qmul = '0; cfg_shift = '0;
      cfg_offset = '0; act_min = -8'sd128; act_max = 8'sd127; in_valid = 1'b0;
      in_acc = '0; in_ch = '0; in_last = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
      for (int i = 0; i < 64; i++) begin
         shQ[i] = '0; shO[i] = '0; shS[i] = 0;
      end

      repeat (3) @(posedge clk);
      #2;
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_out_data", out_data, 0);
      checkOutput("rst_out_last", out_last, 0);
      checkOutput("rst_sat_cnt", sat_cnt, 0);
      checkOutput("rst_in_ready", in_ready, 1);
      rst = 1'b0;
      tick;

      $display("[TB] basic scaling, offset and rounding");
      writeCfg(0, 32'sd1 <<< 30, 2, 0);
      sendBeat(1000, 0, 1'b0);
      checkLatency("latency_basic");
      drain;
      writeCfg(0, 32'sd1 <<< 30, 2, -3);
      sendBeat(1000, 0, 1'b0);
      drain;
      writeCfg(0, 32'sd1 <<< 30, 3, 0);
      sendBeat(-1000, 0, 1'b0);
      drain;

      $display("[TB] INT_MIN special case and saturation counter");
      writeCfg(2, 32'sh8000_0000, 0, 0);
      sendBeat(32'sh8000_0000, 2, 1'b0);
      drain;
      checkOutput("sat_after_intmin", sat_cnt, expSat);
      checkOutput("sat_exactly_one", sat_cnt, 1);
      sat_clr = 1'b1;
      tick;
      sat_clr = 1'b0;
      expSat  = 0;
      checkOutput("sat_clr", sat_cnt, 0);

      $display("[TB] random channels and parameters");
      for (int c = 1; c <= 3; c++) begin
         writeCfg(c, $urandom, $urandom_range(0, 31), int'($urandom_range(0, 200)) - 100);
      end
      for (int i = 0; i < 12; i++) begin
         sendBeat($urandom, $urandom_range(1, 3), 1'b0);
      end
      drain;
      checkOutput("sat_random", sat_cnt, expSat);

      $display("[TB] inverted clamp window");
      act_min = 8'sd10;
      act_max = -8'sd10;
      sendBeat(1000, 0, 1'b0);
      sendBeat(-5000, 0, 1'b0);
      drain;
      act_min = -8'sd128;
      act_max = 8'sd127;
      checkOutput("sat_inverted", sat_cnt, expSat);

      $display("[TB] table write with beats in flight");
      writeCfg(5, 32'sd1 <<< 30, 1, 0);
      sendBeat(20, 5, 1'b0);
      sendBeat(40, 5, 1'b0);
      applyStimulus(1'b1, 20, 5, 1'b0, 1'b1, 5, 32'sd1 <<< 30, 0, 10);
      sendBeat(20, 5, 1'b0);
      drain;

      $display("[TB] backpressure mid-stream");
      for (int i = 0; i < 8; i++) begin
         if (i == 3) begin
            out_ready = 1'b0;
            fork
               begin
                  repeat (6) @(posedge clk);
                  #1;
                  checkOutput("in_ready_stalled", in_ready, 0);
                  repeat (4) @(posedge clk);
                  #1;
                  out_ready = 1'b1;
               end
            join_none
         end
         sendBeat(i * 1000 - 3000, 0, i == 7);
      end
      drain;
      checkOutput("sat_stream", sat_cnt, expSat);

      $display("[TB] reset with beats in flight");
      out_ready = 1'b0;
      sendBeat(100, 0, 1'b0);
      sendBeat(200, 0, 1'b0);
      sendBeat(300, 0, 1'b1);
      tick;
      checkOutput("valid_before_rst", out_valid, 1);
      #2 rst = 1'b1;
      #1;
      checkOutput("valid_async_rst", out_valid, 0);
      checkOutput("in_ready_rst", in_ready, 1);
      checkOutput("sat_rst", sat_cnt, 0);
      scb.delete();
      expSat = 0;
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      tick;
      sendBeat(1000, 0, 1'b1);
      checkLatency("latency_after_rst");
      drain;

      checkOutput("final_scb_empty", scb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
      $finish;
   end

endmodule
